counter_timer_param: RTL and testbench

COUNTER_TIMER_PARAM -- requirements
Module: counter_timer_param

---
 rtl/counter_timer_param.sv | 174 +++++++++++++++++
 tb/tb_counter_timer_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_timer_param.sv
// Chainable up/down counter-timer with prescaler, byte-writable registers,
// oneshot/continuous modes, PWM output, input capture and interrupt pulse.
module counter_timer_param #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned PSC_W = 8
) (
   input  logic               clkin,
   input  logic               resetn,
   input  logic               reg_cfg_we,
   input  logic [31:0]        reg_cfg_di,
   output logic [31:0]        reg_cfg_do,
   input  logic [WIDTH/8-1:0] reg_val_we,
   input  logic [WIDTH-1:0]   reg_val_di,
   output logic [WIDTH-1:0]   reg_val_do,
   input  logic [WIDTH/8-1:0] reg_cmp_we,
   input  logic [WIDTH-1:0]   reg_cmp_di,
   output logic [WIDTH-1:0]   reg_cmp_do,
   input  logic [WIDTH/8-1:0] reg_dat_we,
   input  logic [WIDTH-1:0]   reg_dat_di,
   output logic [WIDTH-1:0]   reg_dat_do,
   output logic [WIDTH-1:0]   reg_cap_do,
   input  logic               capture_in,
   input  logic               enable_in,
   input  logic               strobe_in,
   input  logic               stop_in,
   output logic               enable_out,
   output logic               strobe_out,
   output logic               stop_out,
   output logic               pwm_out,
   output logic               irq_out
);

   localparam int NB = WIDTH / 8;

   logic [6:0]       cfg_q;
   logic [PSC_W-1:0] prescale_q;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [WIDTH-1:0] cmp_q, cmp_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [WIDTH-1:0] cap_q;
   logic [PSC_W-1:0] psc_q, psc_d, psc_next;
   logic             cap_flag_q, cap_prev_q, cap_evt_q;
   logic             loc_en_prev_q;
   logic             stop_q, stop_d;
   logic             strobe_q, strobe_d;
   logic             pwm_q, pwm_d;
   logic             irq_q;

   logic enable, oneshot, updown, chain, irq_ena, pwm_ena, cap_irq_ena;
   logic loc_enable, tick, at_term, dat_wr, cap_rise;
   logic unused_cfg_di;

   assign enable      = cfg_q[0];
   assign oneshot     = cfg_q[1];
   assign updown      = cfg_q[2];
   assign chain       = cfg_q[3];
   assign irq_ena     = cfg_q[4];
   assign pwm_ena     = cfg_q[5];
   assign cap_irq_ena = cfg_q[6];

   assign loc_enable    = chain ? (enable & enable_in) : enable;
   assign dat_wr        = |reg_dat_we;
   assign cap_rise      = capture_in & ~cap_prev_q;
   assign unused_cfg_di = ^reg_cfg_di;

   always_comb begin
      reload_d = reload_q;
      cmp_d    = cmp_q;
      for (int b = 0; b < NB; b++) begin
         if (reg_val_we[b]) reload_d[8*b +: 8] = reg_val_di[8*b +: 8];
         if (reg_cmp_we[b]) cmp_d[8*b +: 8] = reg_cmp_di[8*b +: 8];
      end
   end

   always_comb begin
      value_d  = value_q;
      stop_d   = stop_q;
      strobe_d = 1'b0;
      psc_d    = psc_q;
      at_term  = updown ? (value_q == reload_q) : (value_q == '0);
      tick     = chain ? strobe_in : (psc_q == prescale_q);
      psc_next = (chain || tick) ? '0 : psc_q + 1'b1;

      if (!loc_enable) begin
         stop_d = 1'b0;
         psc_d  = '0;
      end else if (!loc_en_prev_q) begin
         // Re-enable edge: restart from the mode's start value, no tick this cycle
         value_d = updown ? '0 : reload_q;
         stop_d  = 1'b0;
         psc_d   = '0;
      end else begin
         psc_d = psc_next;
         if (!dat_wr && !stop_q) begin
            if ((chain && stop_in && at_term) || (tick && at_term)) begin
               strobe_d = 1'b1;
               if (oneshot) stop_d = 1'b1;
               else         value_d = updown ? '0 : reload_q;
            end else if (tick) begin
               value_d = updown ? value_q + 1'b1 : value_q - 1'b1;
            end
         end
      end

      // Software writes to the current value override any count this cycle
      for (int b = 0; b < NB; b++) begin
         if (reg_dat_we[b]) value_d[8*b +: 8] = reg_dat_di[8*b +: 8];
      end

      pwm_d = pwm_ena & loc_enable & (value_q < cmp_q);
   end

   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         cfg_q         <= '0;
         prescale_q    <= '0;
         reload_q      <= '0;
         cmp_q         <= '0;
         value_q       <= '0;
         cap_q         <= '0;
         psc_q         <= '0;
         cap_flag_q    <= 1'b0;
         cap_prev_q    <= 1'b0;
         cap_evt_q     <= 1'b0;
         loc_en_prev_q <= 1'b0;
         stop_q        <= 1'b0;
         strobe_q      <= 1'b0;
         pwm_q         <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         if (reg_cfg_we) begin
            cfg_q      <= reg_cfg_di[6:0];
            prescale_q <= reg_cfg_di[8 +: PSC_W];
         end
         reload_q      <= reload_d;
         cmp_q         <= cmp_d;
         value_q       <= value_d;
         psc_q         <= psc_d;
         loc_en_prev_q <= loc_enable;
         stop_q        <= stop_d;
         strobe_q      <= strobe_d;
         pwm_q         <= pwm_d;
         cap_prev_q    <= capture_in;
         cap_evt_q     <= cap_rise;
         // Capture beats a same-cycle flag clear
         if (cap_rise) begin
            cap_q      <= value_q;
            cap_flag_q <= 1'b1;
         end else if (reg_cfg_we && reg_cfg_di[25]) begin
            cap_flag_q <= 1'b0;
         end
         irq_q <= (strobe_q & irq_ena) | (cap_evt_q & cap_irq_ena);
      end
   end

   always_comb begin
      reg_cfg_do              = '0;
      reg_cfg_do[6:0]         = cfg_q;
      reg_cfg_do[8 +: PSC_W]  = prescale_q;
      reg_cfg_do[24]          = stop_q;
      reg_cfg_do[25]          = cap_flag_q;
   end

   assign reg_val_do = reload_q;
   assign reg_cmp_do = cmp_q;
   assign reg_dat_do = value_q;
   assign reg_cap_do = cap_q;
   assign enable_out = enable;
   assign strobe_out = strobe_q;
   assign stop_out   = stop_q;
   assign pwm_out    = pwm_q;
   assign irq_out    = irq_q;

endmodule

// File: tb/tb_counter_timer_param.sv
// Directed self-checking bench: 16-bit main instance plus a chained 8-bit pair.
module tb_counter_timer_param;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Main instance (WIDTH=16)
   logic        cfg_we;
   logic [31:0] cfg_di, cfg_do;
   logic [1:0]  val_we, cmp_we, dat_we;
   logic [15:0] val_di, val_do, cmp_di, cmp_do, dat_di, dat_do, cap_do;
   logic        cap_in, en_out, stb_out, stp_out, pwm_out, irq_out;

   counter_timer_param #(.WIDTH(16), .PSC_W(8)) dut (
      .clkin(clk), .resetn(rstn),
      .reg_cfg_we(cfg_we), .reg_cfg_di(cfg_di), .reg_cfg_do(cfg_do),
      .reg_val_we(val_we), .reg_val_di(val_di), .reg_val_do(val_do),
      .reg_cmp_we(cmp_we), .reg_cmp_di(cmp_di), .reg_cmp_do(cmp_do),
      .reg_dat_we(dat_we), .reg_dat_di(dat_di), .reg_dat_do(dat_do),
      .reg_cap_do(cap_do), .capture_in(cap_in),
      .enable_in(1'b0), .strobe_in(1'b0), .stop_in(1'b0),
      .enable_out(en_out), .strobe_out(stb_out), .stop_out(stp_out),
      .pwm_out(pwm_out), .irq_out(irq_out)
   );

   // Chained pair (WIDTH=8)
   logic        lo_cfg_we, hi_cfg_we, lo_val_we, hi_val_we;
   logic [31:0] lo_cfg_di, hi_cfg_di, lo_cfg_do, hi_cfg_do;
   logic [7:0]  lo_val_di, hi_val_di, lo_val_do, hi_val_do, lo_cmp_do, hi_cmp_do;
   logic [7:0]  lo_dat_do, hi_dat_do, lo_cap_do, hi_cap_do;
   logic        lo_en, lo_stb, lo_stp, lo_pwm, lo_irq;
   logic        hi_en, hi_stb, hi_stp, hi_pwm, hi_irq;

   counter_timer_param #(.WIDTH(8), .PSC_W(8)) u_lo (
      .clkin(clk), .resetn(rstn),
      .reg_cfg_we(lo_cfg_we), .reg_cfg_di(lo_cfg_di), .reg_cfg_do(lo_cfg_do),
      .reg_val_we(lo_val_we), .reg_val_di(lo_val_di), .reg_val_do(lo_val_do),
      .reg_cmp_we(1'b0), .reg_cmp_di(8'h00), .reg_cmp_do(lo_cmp_do),
      .reg_dat_we(1'b0), .reg_dat_di(8'h00), .reg_dat_do(lo_dat_do),
      .reg_cap_do(lo_cap_do), .capture_in(1'b0),
      .enable_in(1'b0), .strobe_in(1'b0), .stop_in(1'b0),
      .enable_out(lo_en), .strobe_out(lo_stb), .stop_out(lo_stp),
      .pwm_out(lo_pwm), .irq_out(lo_irq)
   );

   counter_timer_param #(.WIDTH(8), .PSC_W(8)) u_hi (
      .clkin(clk), .resetn(rstn),
      .reg_cfg_we(hi_cfg_we), .reg_cfg_di(hi_cfg_di), .reg_cfg_do(hi_cfg_do),
      .reg_val_we(hi_val_we), .reg_val_di(hi_val_di), .reg_val_do(hi_val_do),
      .reg_cmp_we(1'b0), .reg_cmp_di(8'h00), .reg_cmp_do(hi_cmp_do),
      .reg_dat_we(1'b0), .reg_dat_di(8'h00), .reg_dat_do(hi_dat_do),
      .reg_cap_do(hi_cap_do), .capture_in(1'b0),
      .enable_in(lo_en), .strobe_in(lo_stb), .stop_in(lo_stp),
      .enable_out(hi_en), .strobe_out(hi_stb), .stop_out(hi_stp),
      .pwm_out(hi_pwm), .irq_out(hi_irq)
   );

   typedef struct {
      logic [1:0]  dat_we;
      logic [15:0] dat_di;
      logic [15:0] exp_dat;
      logic        exp_stb;
      logic        exp_irq;
   } vec_t;
   vec_t vecs[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic cfg_wr(input logic [31:0] d);
      cfg_di = d;
      cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int hi_cnt;
      logic seen;
      cfg_we = 0; cfg_di = 0; val_we = 0; val_di = 0; cmp_we = 0; cmp_di = 0;
      dat_we = 0; dat_di = 0; cap_in = 0;
      lo_cfg_we = 0; hi_cfg_we = 0; lo_cfg_di = 0; hi_cfg_di = 0;
      lo_val_we = 0; hi_val_we = 0; lo_val_di = 0; hi_val_di = 0;

      // Down-count vectors: reload=3, one dat write mid-sequence
      vecs[0] = '{2'b00, 16'h0000, 16'd3, 1'b0, 1'b0};
      vecs[1] = '{2'b00, 16'h0000, 16'd2, 1'b0, 1'b0};
      vecs[2] = '{2'b00, 16'h0000, 16'd1, 1'b0, 1'b0};
      vecs[3] = '{2'b00, 16'h0000, 16'd0, 1'b0, 1'b0};
      vecs[4] = '{2'b00, 16'h0000, 16'd3, 1'b1, 1'b0};
      vecs[5] = '{2'b00, 16'h0000, 16'd2, 1'b0, 1'b1};
      vecs[6] = '{2'b00, 16'h0000, 16'd1, 1'b0, 1'b0};
      vecs[7] = '{2'b11, 16'h0007, 16'd7, 1'b0, 1'b0};
      vecs[8] = '{2'b00, 16'h0000, 16'd6, 1'b0, 1'b0};
      vecs[9] = '{2'b00, 16'h0000, 16'd5, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_cfg", cfg_do, 32'h0);
      chk("rst_outs", {en_out, stb_out, stp_out, pwm_out, irq_out}, 32'h0);
      chk("rst_regs", {val_do, cmp_do}, 32'h0);
      chk("rst_dat_cap", {dat_do, cap_do}, 32'h0);
      rstn = 1'b1;
      step();

      // Down continuous with irq
      val_we = 2'b11; val_di = 16'd3; step(); val_we = 2'b00;
      cfg_wr(32'h0000_0011);
      chk("cfg_readback", cfg_do, 32'h0000_0011);
      chk("enable_out", en_out, 1'b1);
      for (int i = 0; i < 10; i++) begin
         dat_we = vecs[i].dat_we;
         dat_di = vecs[i].dat_di;
         step();
         dat_we = 2'b00;
         chk($sformatf("down[%0d].dat", i), dat_do, vecs[i].exp_dat);
         chk($sformatf("down[%0d].stb", i), stb_out, vecs[i].exp_stb);
         chk($sformatf("down[%0d].irq", i), irq_out, vecs[i].exp_irq);
      end
      cfg_wr(32'h0);
      step();
      chk("disabled_hold", dat_do, 16'd4);
      chk("disabled_outs", {stb_out, stp_out, pwm_out}, 32'h0);

      // Up oneshot, prescale=2
      val_we = 2'b11; val_di = 16'd5; step(); val_we = 2'b00;
      cfg_wr(32'h0000_0207);
      for (int k = 1; k <= 22; k++) begin
         int ev;
         step();
         ev = (k - 1) / 3;
         if (ev > 5) ev = 5;
         chk($sformatf("oneshot[%0d].dat", k), dat_do, ev);
         chk($sformatf("oneshot[%0d].stb", k), stb_out, (k == 19));
         chk($sformatf("oneshot[%0d].stop", k), stp_out, (k >= 19));
      end
      chk("oneshot_cfg_do", cfg_do, 32'h0100_0207);
      cfg_wr(32'h0);

      // PWM: up, reload=9, cmp=3
      val_we = 2'b11; val_di = 16'd9; cmp_we = 2'b11; cmp_di = 16'd3;
      step();
      val_we = 2'b00; cmp_we = 2'b00;
      cfg_wr(32'h0000_0025);
      hi_cnt = 0;
      for (int k = 1; k <= 21; k++) begin
         step();
         chk($sformatf("pwm[%0d].dat", k), dat_do, (k - 1) % 10);
         chk($sformatf("pwm[%0d].out", k), pwm_out, (k >= 2) && (((k - 2) % 10) < 3));
         if (k >= 2 && pwm_out) hi_cnt++;
      end
      chk("pwm_high_count", hi_cnt, 6);
      cmp_we = 2'b11; cmp_di = 16'd0; step(); cmp_we = 2'b00;
      step();
      hi_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (pwm_out) hi_cnt++;
      end
      chk("pwm_cmp0_count", hi_cnt, 0);

      // Byte enables
      cmp_we = 2'b01; cmp_di = 16'h1234; step();
      chk("cmp_byte0", cmp_do, 16'h0034);
      cmp_we = 2'b10; cmp_di = 16'h5678; step(); cmp_we = 2'b00;
      chk("cmp_byte1", cmp_do, 16'h5634);
      val_we = 2'b10; val_di = 16'hAB00; step(); val_we = 2'b00;
      chk("val_byte1", val_do, 16'hAB09);
      cfg_wr(32'h0);

      // Capture while disabled, capture irq
      cfg_wr(32'h0000_0040);
      dat_we = 2'b11; dat_di = 16'h1234; step(); dat_we = 2'b00;
      chk("dat_write", dat_do, 16'h1234);
      cap_in = 1'b1; step(); cap_in = 1'b0;
      chk("cap_value", cap_do, 16'h1234);
      chk("cap_flag_set", cfg_do[25], 1'b1);
      chk("cap_irq_early", irq_out, 1'b0);
      step();
      chk("cap_irq", irq_out, 1'b1);
      step();
      chk("cap_irq_pulse", irq_out, 1'b0);
      cfg_wr(32'h0200_0040);
      chk("cap_flag_clr", cfg_do[25], 1'b0);
      dat_we = 2'b11; dat_di = 16'h0042; step(); dat_we = 2'b00;
      cap_in = 1'b1; cfg_di = 32'h0200_0040; cfg_we = 1'b1;
      step();
      cap_in = 1'b0; cfg_we = 1'b0;
      chk("cap_wins_clr", cfg_do[25], 1'b1);
      chk("cap_value2", cap_do, 16'h0042);

      // Reset mid-count
      val_we = 2'b11; val_di = 16'd3; step(); val_we = 2'b00;
      cfg_wr(32'h0000_0011);
      repeat (3) step();
      chk("pre_rst_dat", dat_do, 16'd1);
      rstn = 1'b0;
      #1;
      chk("rst_async_outs", {en_out, stb_out, stp_out, pwm_out, irq_out}, 32'h0);
      chk("rst_async_regs", {dat_do, cap_do}, 32'h0);
      chk("rst_async_cfg", cfg_do, 32'h0);
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (stb_out || irq_out) seen = 1'b1;
      end
      rstn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         if (stb_out || irq_out) seen = 1'b1;
      end
      chk("rst_no_pulse", seen, 1'b0);
      chk("rst_val_cmp", {val_do, cmp_do}, 32'h0);

      // Chained pair: high counts once per 256 low ticks
      lo_val_we = 1'b1; lo_val_di = 8'hFF; hi_val_we = 1'b1; hi_val_di = 8'hFF;
      step();
      lo_val_we = 1'b0; hi_val_we = 1'b0;
      lo_cfg_we = 1'b1; lo_cfg_di = 32'h05; hi_cfg_we = 1'b1; hi_cfg_di = 32'h0D;
      step();
      lo_cfg_we = 1'b0; hi_cfg_we = 1'b0;
      for (int k = 1; k <= 514; k++) begin
         step();
         if (k == 256) chk("chain_lo_ff", lo_dat_do, 8'hFF);
         if (k == 257) begin
            chk("chain_lo_wrap", {lo_dat_do, 7'b0, lo_stb}, 16'h0001);
            chk("chain_hi_257", hi_dat_do, 8'd0);
         end
         if (k == 258) chk("chain_hi_258", hi_dat_do, 8'd1);
         if (k == 513) chk("chain_hi_513", hi_dat_do, 8'd1);
         if (k == 514) chk("chain_hi_514", hi_dat_do, 8'd2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
